// File: rtl/noc_flit_framer_pkg.sv
// rtl/noc_flit_framer_pkg.sv - shared preamble/state encodings and lookahead route helper
package noc_flit_framer_pkg;

    typedef enum logic [1:0] {
        PRE_BODY = 2'b00,
        PRE_TAIL = 2'b01,
        PRE_HDR  = 2'b10,
        PRE_ONE  = 2'b11
    } preamble_e;

    typedef enum logic {
        ST_IDLE,
        ST_PAYLOAD
    } state_e;

    // Coordinates are zero-extended so the compare stays unsigned for any YX_W up to 8.
    function automatic logic [4:0] route_bits(input logic [7:0] ly, input logic [7:0] lx,
                                              input logic [7:0] ry, input logic [7:0] rx);
        logic [4:0] r;
        r = ((ly < ry) ? 5'b01110 : 5'b01101)
          & ((lx > rx) ? 5'b00100 : 5'b11011)
          & ((lx < rx) ? 5'b01000 : 5'b10111);
        if (ly == ry && lx == rx) begin
            r = 5'b10000;
        end
        return r;
    endfunction

endpackage

// File: rtl/noc_flit_framer_arb.sv
// rtl/noc_flit_framer_arb.sv - round-robin arbiter with pointer advanced on packet completion
module noc_rr_arbiter #(
    parameter int N_CH  = 2,
    parameter int IDX_W = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N_CH-1:0]  req_i,
    input  logic             adv_i,
    input  logic [IDX_W-1:0] adv_idx_i,
    output logic [N_CH-1:0]  grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [IDX_W-1:0] ptr_q;
    int               cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand    = 0;
        for (int i = 0; i < N_CH; i++) begin
            cand = (int'(ptr_q) + i) % N_CH;
            if (!any_o && req_i[cand]) begin
                any_o         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = IDX_W'(cand);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (adv_i) begin
            ptr_q <= (adv_idx_i == IDX_W'(N_CH - 1)) ? '0 : adv_idx_i + 1'b1;
        end
    end

endmodule

// File: rtl/noc_flit_framer.sv
// rtl/noc_flit_framer.sv - multi-channel NoC packet framer: header flit then req_len payload flits
module noc_flit_framer
    import noc_flit_framer_pkg::*;
#(
    parameter  int FLIT_W     = 66,
    parameter  int PREAMBLE_W = 2,
    parameter  int YX_W       = 3,
    parameter  int MSG_W      = 5,
    parameter  int RSV_W      = 8,
    parameter  int ROUTE_W    = 5,
    parameter  int N_CH       = 2,
    parameter  int MAX_LEN    = 16,
    localparam int LEN_W      = $clog2(MAX_LEN + 1),
    localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int DAT_W      = FLIT_W - PREAMBLE_W
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [YX_W-1:0]       local_y_i,
    input  logic [YX_W-1:0]       local_x_i,
    input  logic [N_CH-1:0]       req_valid_i,
    output logic [N_CH-1:0]       req_ready_o,
    input  logic [N_CH*YX_W-1:0]  req_y_i,
    input  logic [N_CH*YX_W-1:0]  req_x_i,
    input  logic [N_CH*MSG_W-1:0] req_msg_i,
    input  logic [N_CH*RSV_W-1:0] req_rsv_i,
    input  logic [N_CH*LEN_W-1:0] req_len_i,
    input  logic [N_CH-1:0]       dat_valid_i,
    output logic [N_CH-1:0]       dat_ready_o,
    input  logic [N_CH*DAT_W-1:0] dat_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [FLIT_W-1:0]     out_flit_o,
    output logic [CH_W-1:0]       out_ch_o
);

    localparam int LY_LSB  = FLIT_W - PREAMBLE_W - YX_W;
    localparam int LX_LSB  = LY_LSB - YX_W;
    localparam int RY_LSB  = LX_LSB - YX_W;
    localparam int RX_LSB  = RY_LSB - YX_W;
    localparam int MSG_LSB = RX_LSB - MSG_W;
    localparam int RSV_LSB = MSG_LSB - RSV_W;

    state_e              state_q, state_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic                out_valid_q, out_valid_d;
    logic [FLIT_W-1:0]   out_flit_q, out_flit_d;
    logic [CH_W-1:0]     out_ch_q, out_ch_d;

    logic [N_CH-1:0]     grant;
    logic [CH_W-1:0]     gidx;
    logic                any_req;
    logic                adv;
    logic [CH_W-1:0]     adv_idx;
    logic                load;
    logic [LEN_W-1:0]    len_raw, len_eff;
    logic [YX_W-1:0]     g_y, g_x;
    logic [FLIT_W-1:0]   hdr;
    logic [DAT_W-1:0]    dat_g;
    logic [N_CH-1:0]     req_ready_c, dat_ready_c;

    noc_rr_arbiter #(
        .N_CH  (N_CH),
        .IDX_W (CH_W)
    ) u_arb (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_i     (req_valid_i),
        .adv_i     (adv),
        .adv_idx_i (adv_idx),
        .grant_o   (grant),
        .idx_o     (gidx),
        .any_o     (any_req)
    );

    assign load    = !out_valid_q || out_ready_i;
    assign len_raw = req_len_i[int'(gidx)*LEN_W +: LEN_W];
    assign len_eff = (len_raw > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len_raw;
    assign g_y     = req_y_i[int'(gidx)*YX_W +: YX_W];
    assign g_x     = req_x_i[int'(gidx)*YX_W +: YX_W];
    assign dat_g   = dat_data_i[int'(ch_q)*DAT_W +: DAT_W];

    always_comb begin
        hdr = '0;
        hdr[FLIT_W-1 -: PREAMBLE_W] = (len_eff == '0) ? PREAMBLE_W'(PRE_ONE) : PREAMBLE_W'(PRE_HDR);
        hdr[LY_LSB +: YX_W]   = local_y_i;
        hdr[LX_LSB +: YX_W]   = local_x_i;
        hdr[RY_LSB +: YX_W]   = g_y;
        hdr[RX_LSB +: YX_W]   = g_x;
        hdr[MSG_LSB +: MSG_W] = req_msg_i[int'(gidx)*MSG_W +: MSG_W];
        hdr[RSV_LSB +: RSV_W] = req_rsv_i[int'(gidx)*RSV_W +: RSV_W];
        hdr[ROUTE_W-1:0]      = ROUTE_W'(route_bits(8'(local_y_i), 8'(local_x_i), 8'(g_y), 8'(g_x)));
    end

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_flit_d  = out_flit_q;
        out_ch_d    = out_ch_q;
        req_ready_c = '0;
        dat_ready_c = '0;
        adv         = 1'b0;
        adv_idx     = gidx;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    out_valid_d = 1'b0;
                    if (any_req) begin
                        req_ready_c = grant;
                        out_valid_d = 1'b1;
                        out_flit_d  = hdr;
                        out_ch_d    = gidx;
                        if (len_eff == '0) begin
                            adv = 1'b1;
                        end else begin
                            ch_d    = gidx;
                            len_d   = len_eff;
                            cnt_d   = LEN_W'(1);
                            state_d = ST_PAYLOAD;
                        end
                    end
                end
            end
            ST_PAYLOAD: begin
                dat_ready_c[ch_q] = load;
                adv_idx           = ch_q;
                if (load) begin
                    out_valid_d = 1'b0;
                    if (dat_valid_i[ch_q]) begin
                        out_valid_d = 1'b1;
                        out_ch_d    = ch_q;
                        out_flit_d  = {(cnt_q == len_q) ? PREAMBLE_W'(PRE_TAIL) : PREAMBLE_W'(PRE_BODY), dat_g};
                        cnt_d       = cnt_q + 1'b1;
                        if (cnt_q == len_q) begin
                            state_d = ST_IDLE;
                            adv     = 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs are combinational, so force them low while reset is held.
    assign req_ready_o = rst_ni ? req_ready_c : '0;
    assign dat_ready_o = rst_ni ? dat_ready_c : '0;
    assign out_valid_o = out_valid_q;
    assign out_flit_o  = out_flit_q;
    assign out_ch_o    = out_ch_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            ch_q        <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_flit_q  <= '0;
            out_ch_q    <= '0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_flit_q  <= out_flit_d;
            out_ch_q    <= out_ch_d;
        end
    end

endmodule

// File: tb/tb_noc_flit_framer.sv
// tb/tb_noc_flit_framer.sv - scoreboard bench for noc_flit_framer with directed packets
module tb_noc_flit_framer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [2:0]   local_y, local_x;
    logic [1:0]   req_valid, req_ready;
    logic [5:0]   req_y, req_x;
    logic [9:0]   req_msg;
    logic [15:0]  req_rsv;
    logic [9:0]   req_len;
    logic [1:0]   dat_valid, dat_ready;
    logic [127:0] dat_data;
    logic         out_valid, out_ready;
    logic [65:0]  out_flit;
    logic [0:0]   out_ch;

    typedef struct packed {
        logic [65:0] flit;
        logic [0:0]  ch;
    } exp_t;

    exp_t        exp_q[$];
    int          pop_cyc[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_pop = 0;
    int          cyc = 0;
    int          base;
    logic        ok;
    logic [65:0] cap;

    noc_flit_framer dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .local_y_i   (local_y),
        .local_x_i   (local_x),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_y_i     (req_y),
        .req_x_i     (req_x),
        .req_msg_i   (req_msg),
        .req_rsv_i   (req_rsv),
        .req_len_i   (req_len),
        .dat_valid_i (dat_valid),
        .dat_ready_o (dat_ready),
        .dat_data_i  (dat_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_flit_o  (out_flit),
        .out_ch_o    (out_ch)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [65:0] mk_hdr(input logic [1:0] pre, input logic [2:0] ly, input logic [2:0] lx,
                                           input logic [2:0] ry, input logic [2:0] rx, input logic [4:0] msg,
                                           input logic [7:0] rsv, input logic [4:0] route);
        return {pre, ly, lx, ry, rx, msg, rsv, 34'b0, route};
    endfunction

    function automatic logic [65:0] mk_dat(input logic [1:0] pre, input logic [63:0] d);
        return {pre, d};
    endfunction

    task automatic push(input logic [65:0] f, input logic [0:0] ch);
        exp_t e;
        e.flit = f;
        e.ch   = ch;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_flit: got %0h expected none", out_flit);
            end else begin
                mon_e = exp_q.pop_front();
                chk("flit", {62'b0, out_flit}, {62'b0, mon_e.flit});
                chk("out_ch", {127'b0, out_ch}, {127'b0, mon_e.ch});
            end
            pop_cyc.push_back(cyc);
            n_pop++;
        end
    end

    task automatic do_req(input int ch, input logic [2:0] ry, input logic [2:0] rx, input logic [4:0] msg,
                          input logic [7:0] rsv, input logic [4:0] len);
        logic got;
        got = 1'b0;
        req_y[ch*3 +: 3]   = ry;
        req_x[ch*3 +: 3]   = rx;
        req_msg[ch*5 +: 5] = msg;
        req_rsv[ch*8 +: 8] = rsv;
        req_len[ch*5 +: 5] = len;
        req_valid[ch]      = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (req_ready[ch]) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("req_timeout", 128'(got), 128'd1);
        @(posedge clk);
        #1 req_valid[ch] = 1'b0;
    endtask

    task automatic do_data(input int ch, input logic [63:0] d);
        logic got;
        got = 1'b0;
        dat_data[ch*64 +: 64] = d;
        dat_valid[ch]         = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (dat_ready[ch]) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("dat_timeout", 128'(got), 128'd1);
        @(posedge clk);
        #1 dat_valid[ch] = 1'b0;
    endtask

    task automatic drain();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic chan_drv(input int ch);
        for (int k = 0; k < 2; k++) begin
            if (ch == 0) begin
                do_req(0, 3'd1, 3'd1, 5'h04, 8'h11, 5'd1);
                do_data(0, 64'h1000 + 64'(k));
            end else begin
                do_req(1, 3'd0, 3'd0, 5'h05, 8'h22, 5'd1);
                do_data(1, 64'h2000 + 64'(k));
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; local_y = '0; local_x = '0; req_valid = '0; req_y = '0; req_x = '0;
        req_msg = '0; req_rsv = '0; req_len = '0; dat_valid = '0; dat_data = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_out_flit", {62'b0, out_flit}, 128'd0);
        chk("rst_out_ch", 128'(out_ch), 128'd0);
        chk("rst_req_ready", 128'(req_ready), 128'd0);
        chk("rst_dat_ready", 128'(dat_ready), 128'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single-flit packet
        local_y = 3'd1; local_x = 3'd1;
        push(mk_hdr(2'b11, 3'd1, 3'd1, 3'd2, 3'd3, 5'h03, 8'h00, 5'b01000), 1'b0);
        do_req(0, 3'd2, 3'd3, 5'h03, 8'h00, 5'd0);
        drain();

        // three payload flits, expected in four consecutive cycles
        local_y = 3'd2; local_x = 3'd2;
        pop_cyc.delete();
        push(mk_hdr(2'b10, 3'd2, 3'd2, 3'd0, 3'd2, 5'h0A, 8'h5C, 5'b00001), 1'b0);
        push(mk_dat(2'b00, 64'hA), 1'b0);
        push(mk_dat(2'b00, 64'hB), 1'b0);
        push(mk_dat(2'b01, 64'hC), 1'b0);
        do_req(0, 3'd0, 3'd2, 5'h0A, 8'h5C, 5'd3);
        do_data(0, 64'hA);
        do_data(0, 64'hB);
        do_data(0, 64'hC);
        drain();
        chk("t2_flit_count", 128'(pop_cyc.size()), 128'd4);
        if (pop_cyc.size() == 4) chk("t2_span", 128'(pop_cyc[3] - pop_cyc[0]), 128'd3);

        // local eject on channel 1
        local_y = 3'd0; local_x = 3'd0;
        push(mk_hdr(2'b11, 3'd0, 3'd0, 3'd0, 3'd0, 5'h1F, 8'hFF, 5'b10000), 1'b1);
        do_req(1, 3'd0, 3'd0, 5'h1F, 8'hFF, 5'd0);
        drain();

        // both channels contend: grants alternate 0,1,0,1
        local_y = 3'd1; local_x = 3'd1;
        for (int k = 0; k < 2; k++) begin
            push(mk_hdr(2'b10, 3'd1, 3'd1, 3'd1, 3'd1, 5'h04, 8'h11, 5'b10000), 1'b0);
            push(mk_dat(2'b01, 64'h1000 + 64'(k)), 1'b0);
            push(mk_hdr(2'b10, 3'd1, 3'd1, 3'd0, 3'd0, 5'h05, 8'h22, 5'b00100), 1'b1);
            push(mk_dat(2'b01, 64'h2000 + 64'(k)), 1'b1);
        end
        fork
            chan_drv(0);
            chan_drv(1);
        join
        drain();

        // downstream stall mid-packet
        push(mk_hdr(2'b10, 3'd1, 3'd1, 3'd3, 3'd1, 5'h06, 8'h33, 5'b00010), 1'b1);
        for (int k = 0; k < 4; k++) push(mk_dat((k == 3) ? 2'b01 : 2'b00, 64'h5000 + 64'(k)), 1'b1);
        base = n_pop;
        fork
            begin
                do_req(1, 3'd3, 3'd1, 5'h06, 8'h33, 5'd4);
                for (int k = 0; k < 4; k++) do_data(1, 64'h5000 + 64'(k));
            end
            begin
                ok = 1'b0;
                for (int i = 0; i < 100; i++) begin
                    @(posedge clk);
                    if (n_pop >= base + 2) begin
                        ok = 1'b1;
                        break;
                    end
                end
                chk("t5_reached", 128'(ok), 128'd1);
                #1 out_ready = 1'b0;
                @(negedge clk);
                cap = out_flit;
                chk("t5_held_flit", {62'b0, cap}, {62'b0, mk_dat(2'b00, 64'h5001)});
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk("t5_valid", 128'(out_valid), 128'd1);
                    chk("t5_flit", {62'b0, out_flit}, {62'b0, cap});
                    chk("t5_dat_ready", 128'(dat_ready[1]), 128'd0);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // oversized length is clamped to 16 payload flits
        push(mk_hdr(2'b10, 3'd1, 3'd1, 3'd1, 3'd1, 5'h07, 8'h44, 5'b10000), 1'b0);
        for (int k = 0; k < 16; k++) push(mk_dat((k == 15) ? 2'b01 : 2'b00, 64'h7000 + 64'(k)), 1'b0);
        do_req(0, 3'd1, 3'd1, 5'h07, 8'h44, 5'd31);
        for (int k = 0; k < 16; k++) do_data(0, 64'h7000 + 64'(k));
        drain();
        chk("clamp_drained", 128'(exp_q.size()), 128'd0);

        // reset after the second of four flits
        local_y = 3'd2; local_x = 3'd2;
        push(mk_hdr(2'b10, 3'd2, 3'd2, 3'd2, 3'd3, 5'h08, 8'h55, 5'b01000), 1'b1);
        push(mk_dat(2'b00, 64'h6000), 1'b1);
        do_req(1, 3'd2, 3'd3, 5'h08, 8'h55, 5'd3);
        do_data(1, 64'h6000);
        dat_data[64 +: 64] = 64'h6001;
        dat_valid[1] = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b0;
        req_valid = 2'b11;
        #1;
        chk("abort_out_valid", 128'(out_valid), 128'd0);
        chk("abort_out_flit", {62'b0, out_flit}, 128'd0);
        chk("abort_out_ch", 128'(out_ch), 128'd0);
        chk("abort_req_ready", 128'(req_ready), 128'd0);
        chk("abort_dat_ready", 128'(dat_ready), 128'd0);
        chk("abort_sb_empty", 128'(exp_q.size()), 128'd0);
        req_valid = 2'b00;
        dat_valid = 2'b00;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // pointer back at 0: channel 0 wins first
        push(mk_hdr(2'b11, 3'd2, 3'd2, 3'd2, 3'd3, 5'h09, 8'h66, 5'b01000), 1'b0);
        push(mk_hdr(2'b11, 3'd2, 3'd2, 3'd2, 3'd1, 5'h0A, 8'h77, 5'b00100), 1'b1);
        fork
            do_req(0, 3'd2, 3'd3, 5'h09, 8'h66, 5'd0);
            do_req(1, 3'd2, 3'd1, 5'h0A, 8'h77, 5'd0);
        join
        drain();

        chk("final_sb_empty", 128'(exp_q.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
